// File: rtl/div_result_sink_if.sv
// Result handshake between the last divider stage, the result sink and its consumer.
// The sink uses the slave modport; the driving environment uses master.
interface div_result_sink_if #(
  parameter int tamanyo = 32
);
  logic               Done_in;
  logic [tamanyo-1:0] Q_in;
  logic [tamanyo-1:0] ACCU_in;
  logic [tamanyo-1:0] M_in;
  logic               SignNum_in;
  logic               SignDen_in;
  logic               Ready;
  logic               Valid;
  logic [tamanyo-1:0] Coc;
  logic [tamanyo-1:0] Res;
  logic               DivZero;

  modport master (
    output Done_in, Q_in, ACCU_in, M_in, SignNum_in, SignDen_in, Ready,
    input  Valid, Coc, Res, DivZero
  );

  modport slave (
    input  Done_in, Q_in, ACCU_in, M_in, SignNum_in, SignDen_in, Ready,
    output Valid, Coc, Res, DivZero
  );
endinterface

// File: rtl/div_result_sink.sv
// Divider output stage: sign correction, divide-by-zero flagging, show-ahead FIFO with drop reporting.
// Optional drop counter output DropCnt is enabled by defining DIV_SINK_DROP_CNT_EN.
module div_result_sink #(
  parameter int tamanyo = 32,
  parameter int DEPTH   = 4
) (
  input  logic                       CLK,
  input  logic                       RSTa,
  input  logic                       Clear,
  div_result_sink_if.slave           bus,
  output logic                       Full,
  output logic [$clog2(DEPTH+1)-1:0] Count,
`ifdef DIV_SINK_DROP_CNT_EN
  output logic                       Overflow,
  output logic [15:0]                DropCnt
`else
  output logic                       Overflow
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [tamanyo-1:0] q_mem [DEPTH];
  logic [tamanyo-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]   z_mem;

  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count_q;
  logic               overflow_q;

  logic               push;
  logic               pop;
  logic               drop;
  logic               valid_w;
  logic               full_w;
  logic               div_zero_in;
  logic [tamanyo-1:0] q_conv;
  logic [tamanyo-1:0] r_conv;

  // A zero divisor overrides the sign handling with a fixed all-ones/zero result.
  always_comb begin
    div_zero_in = (bus.M_in == '0);
    q_conv      = (bus.SignNum_in ^ bus.SignDen_in) ? -bus.Q_in : bus.Q_in;
    r_conv      = bus.SignNum_in ? -bus.ACCU_in : bus.ACCU_in;
    if (div_zero_in) begin
      q_conv = '1;
      r_conv = '0;
    end
  end

  assign valid_w = (count_q != '0);
  assign full_w  = (count_q == CW'(DEPTH));
  assign pop     = valid_w && bus.Ready;
  // The pipeline cannot stall, so a full FIFO only accepts when the head leaves in the same cycle.
  assign push    = bus.Done_in && (!full_w || pop);
  assign drop    = bus.Done_in && full_w && !pop;

  always_ff @(posedge CLK) begin
    if (push) begin
      q_mem[wr_ptr]  <= q_conv;
      r_mem[wr_ptr]  <= r_conv;
      z_mem[wr_ptr]  <= div_zero_in;
    end
  end

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A drop in the same cycle as Clear takes priority so no loss goes unreported.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (Clear) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef DIV_SINK_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      if (Clear)
        drop_cnt_q <= 16'd1;
      else if (drop_cnt_q != 16'hFFFF)
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end else if (Clear) begin
      drop_cnt_q <= '0;
    end
  end

  assign DropCnt = drop_cnt_q;
`endif

  assign bus.Valid   = valid_w;
  assign bus.Coc     = valid_w ? q_mem[rd_ptr] : '0;
  assign bus.Res     = valid_w ? r_mem[rd_ptr] : '0;
  assign bus.DivZero = valid_w ? z_mem[rd_ptr] : 1'b0;
  assign Full        = full_w;
  assign Count       = count_q;
  assign Overflow    = overflow_q;

endmodule

// File: tb/tb_div_result_sink.sv
// Directed bench for div_result_sink: sign correction, divide-by-zero, overflow/drop, clear and reset.
module tb_div_result_sink;

  logic       CLK;
  logic       RSTa;
  logic       Clear;
  logic       Full;
  logic [2:0] Count;
  logic       Overflow;
`ifdef DIV_SINK_DROP_CNT_EN
  logic [15:0] DropCnt;
`endif

  int checks;
  int errors;

  div_result_sink_if #(.tamanyo(32)) bus ();

  div_result_sink #(.tamanyo(32), .DEPTH(4)) dut (
    .CLK      (CLK),
    .RSTa     (RSTa),
    .Clear    (Clear),
    .bus      (bus),
    .Full     (Full),
    .Count    (Count),
`ifdef DIV_SINK_DROP_CNT_EN
    .Overflow (Overflow),
    .DropCnt  (DropCnt)
`else
    .Overflow (Overflow)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic applyStimulus(input logic done, input logic [31:0] q, input logic [31:0] accu,
                               input logic [31:0] m, input logic sn, input logic sd, input logic rdy);
    bus.Done_in    = done;
    bus.Q_in       = q;
    bus.ACCU_in    = accu;
    bus.M_in       = m;
    bus.SignNum_in = sn;
    bus.SignDen_in = sd;
    bus.Ready      = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RSTa   = 1'b0;
    Clear  = 1'b0;
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("rst_valid",    32'(bus.Valid),   32'd0);
    checkOutput("rst_count",    32'(Count),       32'd0);
    checkOutput("rst_full",     32'(Full),        32'd0);
    checkOutput("rst_overflow", 32'(Overflow),    32'd0);
    checkOutput("rst_coc",      bus.Coc,          32'd0);
    checkOutput("rst_divzero",  32'(bus.DivZero), 32'd0);
    #10;
    RSTa = 1'b1;
    step();

    // Negative numerator, positive denominator
    applyStimulus(1'b1, 32'd7, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("t1_valid",   32'(bus.Valid),   32'd1);
    checkOutput("t1_coc",     bus.Coc,          32'hFFFF_FFF9);
    checkOutput("t1_res",     bus.Res,          32'hFFFF_FFFE);
    checkOutput("t1_divzero", 32'(bus.DivZero), 32'd0);
    checkOutput("t1_count",   32'(Count),       32'd1);

    // Each push pops the previous head, so the head is always the newest result
    applyStimulus(1'b1, 32'd5, 32'd1, 32'd3, 1'b1, 1'b1, 1'b1);
    step();
    checkOutput("t2a_count", 32'(Count), 32'd1);
    checkOutput("t2a_coc",   bus.Coc,    32'd5);
    checkOutput("t2a_res",   bus.Res,    32'hFFFF_FFFF);
    applyStimulus(1'b1, 32'd5, 32'd1, 32'd3, 1'b0, 1'b1, 1'b1);
    step();
    checkOutput("t2b_coc", bus.Coc, 32'hFFFF_FFFB);
    checkOutput("t2b_res", bus.Res, 32'd1);

    applyStimulus(1'b1, 32'd9, 32'd4, 32'd0, 1'b1, 1'b0, 1'b1);
    step();
    checkOutput("t3_divzero", 32'(bus.DivZero), 32'd1);
    checkOutput("t3_coc",     bus.Coc,          32'hFFFF_FFFF);
    checkOutput("t3_res",     bus.Res,          32'd0);

    applyStimulus(1'b0, 32'd0, 32'd0, 32'd1, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("drain0_count", 32'(Count),     32'd0);
    checkOutput("drain0_valid", 32'(bus.Valid), 32'd0);
    checkOutput("drain0_coc",   bus.Coc,        32'd0);

    // Six results into a four-entry buffer with no consumer
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 32'(i), 32'd0, 32'd1, 1'b0, 1'b0, 1'b0);
      step();
      if (i == 3) begin
        checkOutput("t4_full3", 32'(Full),     32'd0);
      end
      if (i == 4) begin
        checkOutput("t4_full4", 32'(Full),     32'd1);
        checkOutput("t4_ovf4",  32'(Overflow), 32'd0);
      end
      if (i == 5) begin
        checkOutput("t4_ovf5",   32'(Overflow), 32'd1);
        checkOutput("t4_count5", 32'(Count),    32'd4);
      end
      if (i == 6) begin
        checkOutput("t4_count6", 32'(Count),    32'd4);
      end
    end
`ifdef DIV_SINK_DROP_CNT_EN
    checkOutput("t4_dropcnt", 32'(DropCnt), 32'd2);
`endif
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("t4_drain%0d", i), bus.Coc, 32'(i));
      step();
    end
    checkOutput("t4_empty", 32'(Count), 32'd0);

    Clear = 1'b1;
    step();
    Clear = 1'b0;
    checkOutput("t6_clear_ovf", 32'(Overflow), 32'd0);
`ifdef DIV_SINK_DROP_CNT_EN
    checkOutput("t6_clear_dropcnt", 32'(DropCnt), 32'd0);
`endif

    // Full buffer: a push together with a pop is accepted, not dropped
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 32'(i), 32'd0, 32'd1, 1'b0, 1'b0, 1'b0);
      step();
    end
    checkOutput("t5_full", 32'(Full), 32'd1);
    applyStimulus(1'b1, 32'd10, 32'd0, 32'd1, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("t5_ovf",   32'(Overflow), 32'd0);
    checkOutput("t5_count", 32'(Count),    32'd4);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd1, 1'b0, 1'b0, 1'b1);
    checkOutput("t5_head2", bus.Coc, 32'd2);
    step();
    checkOutput("t5_head3", bus.Coc, 32'd3);
    step();
    checkOutput("t5_head4", bus.Coc, 32'd4);
    step();
    checkOutput("t5_head10", bus.Coc, 32'd10);
    step();
    checkOutput("t5_empty", 32'(Count), 32'd0);

    // Drop and Clear in the same cycle: the drop wins
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 32'(20 + i), 32'd0, 32'd1, 1'b0, 1'b0, 1'b0);
      step();
    end
    applyStimulus(1'b1, 32'd30, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0);
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    checkOutput("clrdrop_ovf", 32'(Overflow), 32'd1);
`ifdef DIV_SINK_DROP_CNT_EN
    checkOutput("clrdrop_dropcnt", 32'(DropCnt), 32'd1);
`endif
    checkOutput("clrdrop_head", bus.Coc, 32'd21);

    applyStimulus(1'b0, 32'd0, 32'd0, 32'd1, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_count3", 32'(Count), 32'd3);
    #2;
    RSTa = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(bus.Valid), 32'd0);
    checkOutput("t6_rst_count", 32'(Count),     32'd0);
    checkOutput("t6_rst_ovf",   32'(Overflow),  32'd0);
    checkOutput("t6_rst_coc",   bus.Coc,        32'd0);
    #2;
    RSTa = 1'b1;
    step();

    applyStimulus(1'b1, 32'd3, 32'd1, 32'd5, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("post_rst_count", 32'(Count), 32'd1);
    checkOutput("post_rst_coc",   bus.Coc,    32'hFFFF_FFFD);
    checkOutput("post_rst_res",   bus.Res,    32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
